// File: rtl/cpu6_trap_pkg.sv
// Shared state encodings and machine-interrupt cause codes for the cpu6 trap controller.
package cpu6_trap_pkg;

  localparam int CPU6_TRAP_ST_SIZE = 3;

  typedef enum logic [CPU6_TRAP_ST_SIZE-1:0] {
    CPU6_TRAP_ST_IDLE       = 3'd0,
    CPU6_TRAP_ST_DRAIN      = 3'd1,
    CPU6_TRAP_ST_MRET_DRAIN = 3'd2,
    CPU6_TRAP_ST_TRAP       = 3'd3,
    CPU6_TRAP_ST_RET        = 3'd4
  } trapState_t;

  localparam logic [3:0] CPU6_MCAUSE_MTI = 4'd7;
  localparam logic [3:0] CPU6_MCAUSE_MEI = 4'd11;

  // External interrupts win over the timer when both are pending.
  function automatic logic [3:0] causeCode(input logic extSel);
    return extSel ? CPU6_MCAUSE_MEI : CPU6_MCAUSE_MTI;
  endfunction

endpackage

// File: rtl/cpu6_trap_cnt.sv
// Saturating drain-timeout counter; tc flags the cycle in which the count reaches MAX.
module cpu6_trap_cnt #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = en & ~clr & (cnt == W'(MAX - 1));

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Interrupt entry / mret return sequencer for cpu6: stall, drain E/M/W, then redirect fetch.
// Optional macro CPU6_TRAP_MCAUSE_EN adds the excp_mcause output and the cause-capture register.
module cpu6_trap_ctrl
  import cpu6_trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tmr_irq_r,
  input  logic            ext_irq_r,
  input  logic            csr_mtie_r,
  input  logic            csr_meie_r,
  input  logic            csr_mstatus_mie_r,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            mretE,
  input  logic [XLEN-1:0] pc_resumeE,
  output logic            empty_pipeline_reqE,
  input  logic            empty_pipeline_ackW,
  output logic            stallF,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic            mret_ena,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_timeout_err
`ifdef CPU6_TRAP_MCAUSE_EN
  ,
  output logic [XLEN-1:0] excp_mcause
`endif
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  trapState_t      state, stateNext;
  logic            irqPend, drainDone, timeoutHit;
  logic            cntClr, cntEn, cntTc;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] capPc, capPcNext;
  logic            reqNext, stallNext, mepcEnaNext, mretEnaNext, redirValidNext, errNext;
  logic [XLEN-1:0] mepcNext, redirPcNext;

  assign irqPend = csr_mstatus_mie_r &
                   ((tmr_irq_r & csr_mtie_r) | (ext_irq_r & csr_meie_r));

  assign cntClr     = (state == CPU6_TRAP_ST_IDLE);
  assign cntEn      = (state == CPU6_TRAP_ST_DRAIN) || (state == CPU6_TRAP_ST_MRET_DRAIN);
  assign drainDone  = empty_pipeline_ackW | cntTc;
  assign timeoutHit = cntTc & ~empty_pipeline_ackW;

  cpu6_trap_cnt #(
    .MAX (ACK_TIMEOUT),
    .W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cntClr),
    .en    (cntEn),
    .cnt   (cnt),
    .tc    (cntTc)
  );

`ifdef CPU6_TRAP_MCAUSE_EN
  logic            capExt, capExtNext;
  logic [XLEN-1:0] mcauseNext;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    stateNext      = state;
    capPcNext      = capPc;
    reqNext        = 1'b0;
    stallNext      = 1'b0;
    mepcEnaNext    = 1'b0;
    mepcNext       = '0;
    mretEnaNext    = 1'b0;
    redirValidNext = 1'b0;
    redirPcNext    = '0;
    errNext        = trap_timeout_err | timeoutHit;
`ifdef CPU6_TRAP_MCAUSE_EN
    capExtNext     = capExt;
    mcauseNext     = '0;
`endif
    unique case (state)
      CPU6_TRAP_ST_IDLE: begin
        if (mretE) begin
          stateNext = CPU6_TRAP_ST_MRET_DRAIN;
          reqNext   = 1'b1;
          stallNext = 1'b1;
        end else if (irqPend) begin
          stateNext = CPU6_TRAP_ST_DRAIN;
          capPcNext = pc_resumeE;
          reqNext   = 1'b1;
          stallNext = 1'b1;
`ifdef CPU6_TRAP_MCAUSE_EN
          capExtNext = ext_irq_r & csr_meie_r;
`endif
        end
      end
      CPU6_TRAP_ST_DRAIN: begin
        stallNext = 1'b1;
        if (drainDone) begin
          stateNext      = CPU6_TRAP_ST_TRAP;
          mepcEnaNext    = 1'b1;
          mepcNext       = capPc;
          redirValidNext = 1'b1;
          redirPcNext    = {csr_mtvec[XLEN-1:2], 2'b00};
`ifdef CPU6_TRAP_MCAUSE_EN
          mcauseNext     = {1'b1, {(XLEN-5){1'b0}}, causeCode(capExt)};
`endif
        end
      end
      CPU6_TRAP_ST_MRET_DRAIN: begin
        stallNext = 1'b1;
        if (drainDone) begin
          stateNext      = CPU6_TRAP_ST_RET;
          mretEnaNext    = 1'b1;
          redirValidNext = 1'b1;
          redirPcNext    = csr_mepc;
        end
      end
      CPU6_TRAP_ST_TRAP, CPU6_TRAP_ST_RET: begin
        // Always pass through IDLE so sequences can never run back to back.
        stateNext = CPU6_TRAP_ST_IDLE;
      end
      default: stateNext = CPU6_TRAP_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= CPU6_TRAP_ST_IDLE;
      capPc               <= '0;
      empty_pipeline_reqE <= 1'b0;
      stallF              <= 1'b0;
      excp_mepc_ena       <= 1'b0;
      excp_mepc           <= '0;
      mret_ena            <= 1'b0;
      redirect_valid      <= 1'b0;
      redirect_pc         <= '0;
      trap_timeout_err    <= 1'b0;
`ifdef CPU6_TRAP_MCAUSE_EN
      capExt              <= 1'b0;
      excp_mcause         <= '0;
`endif
    end else begin
      state               <= stateNext;
      capPc               <= capPcNext;
      empty_pipeline_reqE <= reqNext;
      stallF              <= stallNext;
      excp_mepc_ena       <= mepcEnaNext;
      excp_mepc           <= mepcNext;
      mret_ena            <= mretEnaNext;
      redirect_valid      <= redirValidNext;
      redirect_pc         <= redirPcNext;
      trap_timeout_err    <= errNext;
`ifdef CPU6_TRAP_MCAUSE_EN
      capExt              <= capExtNext;
      excp_mcause         <= mcauseNext;
`endif
    end
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Directed bench for cpu6_trap_ctrl with a timeline-based reference model checked every cycle.
module tb_cpu6_trap_ctrl;

  localparam int XLEN        = 32;
  localparam int ACK_TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            tmr_irq_r, ext_irq_r, csr_mtie_r, csr_meie_r, csr_mstatus_mie_r;
  logic [XLEN-1:0] csr_mtvec, csr_mepc, pc_resumeE;
  logic            mretE;
  logic            empty_pipeline_reqE, empty_pipeline_ackW;
  logic            stallF, excp_mepc_ena, mret_ena, redirect_valid, trap_timeout_err;
  logic [XLEN-1:0] excp_mepc, redirect_pc;
`ifdef CPU6_TRAP_MCAUSE_EN
  logic [XLEN-1:0] excp_mcause;
`endif

  always #5 clk = ~clk;

  cpu6_trap_ctrl #(.XLEN(XLEN), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .tmr_irq_r           (tmr_irq_r),
    .ext_irq_r           (ext_irq_r),
    .csr_mtie_r          (csr_mtie_r),
    .csr_meie_r          (csr_meie_r),
    .csr_mstatus_mie_r   (csr_mstatus_mie_r),
    .csr_mtvec           (csr_mtvec),
    .csr_mepc            (csr_mepc),
    .mretE               (mretE),
    .pc_resumeE          (pc_resumeE),
    .empty_pipeline_reqE (empty_pipeline_reqE),
    .empty_pipeline_ackW (empty_pipeline_ackW),
    .stallF              (stallF),
    .excp_mepc           (excp_mepc),
    .excp_mepc_ena       (excp_mepc_ena),
    .mret_ena            (mret_ena),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .trap_timeout_err    (trap_timeout_err)
`ifdef CPU6_TRAP_MCAUSE_EN
    ,
    .excp_mcause         (excp_mcause)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int edgeCnt = 0;
  int ackAt = -1;
  bit autoAck = 1'b1;
  bit strayAck = 1'b0;
  bit modelOn = 1'b0;

  // Reference model: a sequence is a start edge plus the edge its drain ends on.
  bit              mBusy, mMret, mDone, mErr;
  int              mStart;
  logic [XLEN-1:0] mPc;
  logic [3:0]      mCause;
  logic            eReq, eStall, eMepcEna, eMretEna, eRv;
  logic [XLEN-1:0] eMepc, eRpc, eCause;

  int nReq = 0, nMepcEna = 0, nMretEna = 0;
  int lastRvEdge = 0, lastMepcEdge = 0, lastMretEdge = 0;
  logic [XLEN-1:0] lastMepc = '0, lastRpc = '0, lastCause = '0, lastMretRpc = '0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", nm, act, exp, edgeCnt);
    end
  endtask

  task automatic modelEdge();
    bit pend;
    pend = csr_mstatus_mie_r && ((tmr_irq_r && csr_mtie_r) || (ext_irq_r && csr_meie_r));
    eReq = 0; eStall = 0; eMepcEna = 0; eMretEna = 0; eRv = 0;
    eMepc = '0; eRpc = '0; eCause = '0;
    if (!reset) begin
      mBusy = 0; mErr = 0; modelOn = 1;
    end else if (!mBusy) begin
      if (mretE || pend) begin
        mBusy = 1; mDone = 0; mStart = edgeCnt; mMret = mretE;
        if (!mretE) begin
          mPc = pc_resumeE;
          mCause = (ext_irq_r && csr_meie_r) ? 4'd11 : 4'd7;
        end
        eReq = 1; eStall = 1;
      end
    end else if (!mDone) begin
      eStall = 1;
      if (empty_pipeline_ackW || (edgeCnt - mStart >= ACK_TIMEOUT)) begin
        if (!empty_pipeline_ackW) mErr = 1;
        mDone = 1;
        eRv = 1;
        if (mMret) begin
          eMretEna = 1; eRpc = csr_mepc;
        end else begin
          eMepcEna = 1; eMepc = mPc; eRpc = csr_mtvec & ~32'h3;
          eCause = 32'h8000_0000 | 32'(mCause);
        end
      end
    end else begin
      mBusy = 0;
    end
  endtask

  task automatic compareAll();
    if (!modelOn) return;
    chk("reqE",        32'(empty_pipeline_reqE), 32'(eReq));
    chk("stallF",      32'(stallF),              32'(eStall));
    chk("mepc_ena",    32'(excp_mepc_ena),       32'(eMepcEna));
    chk("mret_ena",    32'(mret_ena),            32'(eMretEna));
    chk("redir_valid", 32'(redirect_valid),      32'(eRv));
    chk("timeout_err", 32'(trap_timeout_err),    32'(mErr));
    if (eMepcEna) chk("excp_mepc", excp_mepc, eMepc);
    if (eRv) chk("redirect_pc", redirect_pc, eRpc);
`ifdef CPU6_TRAP_MCAUSE_EN
    chk("mcause", excp_mcause, eCause);
`endif
    if (empty_pipeline_reqE) nReq++;
    if (excp_mepc_ena) begin
      nMepcEna++; lastMepc = excp_mepc; lastMepcEdge = edgeCnt;
`ifdef CPU6_TRAP_MCAUSE_EN
      lastCause = excp_mcause;
`endif
    end
    if (mret_ena) begin
      nMretEna++; lastMretRpc = redirect_pc; lastMretEdge = edgeCnt;
    end
    if (redirect_valid) begin
      lastRvEdge = edgeCnt; lastRpc = redirect_pc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edgeCnt++;
    modelEdge();
    #1;
    if (empty_pipeline_reqE) ackAt = edgeCnt + 2;
    empty_pipeline_ackW = strayAck || (autoAck && (edgeCnt == ackAt));
    @(negedge clk);
    compareAll();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int m, bReq, bMepc, bMret;
    reset = 1'b0;
    tmr_irq_r = 0; ext_irq_r = 0; csr_mtie_r = 0; csr_meie_r = 0; csr_mstatus_mie_r = 0;
    csr_mtvec = '0; csr_mepc = '0; pc_resumeE = '0; mretE = 0; empty_pipeline_ackW = 0;

    ticks(3);
    chk("rst_stall", 32'(stallF), 0);
    chk("rst_rv",    32'(redirect_valid), 0);
    chk("rst_err",   32'(trap_timeout_err), 0);
    reset = 1'b1;
    tick();

    // Timer interrupt, ack two cycles after the marker.
    csr_mstatus_mie_r = 1; csr_mtie_r = 1; pc_resumeE = 32'h100; csr_mtvec = 32'h80;
    bReq = nReq; bMepc = nMepcEna; m = edgeCnt;
    tmr_irq_r = 1;
    tick();
    tmr_irq_r = 0;
    ticks(8);
    chk("tmr_req_pulses", 32'(nReq - bReq), 1);
    chk("tmr_mepc_pulses", 32'(nMepcEna - bMepc), 1);
    chk("tmr_mepc", lastMepc, 32'h100);
    chk("tmr_redirect", lastRpc, 32'h80);
    chk("tmr_latency", 32'(lastRvEdge - m), 4);
`ifdef CPU6_TRAP_MCAUSE_EN
    chk("tmr_mcause", lastCause, 32'h8000_0007);
`endif

    // Both lines pending: external cause, single trap, unaligned mtvec.
    csr_meie_r = 1; pc_resumeE = 32'h140; csr_mtvec = 32'h87;
    bMepc = nMepcEna;
    tmr_irq_r = 1; ext_irq_r = 1;
    tick();
    tmr_irq_r = 0; ext_irq_r = 0;
    ticks(8);
    chk("both_mepc_pulses", 32'(nMepcEna - bMepc), 1);
    chk("both_mepc", lastMepc, 32'h140);
    chk("both_redirect", lastRpc, 32'h84);
`ifdef CPU6_TRAP_MCAUSE_EN
    chk("both_mcause", lastCause, 32'h8000_000B);
`endif

    // mret and a pending interrupt together: return first, trap afterwards.
    csr_mepc = 32'h200; pc_resumeE = 32'h300; csr_mtvec = 32'h80;
    bReq = nReq; bMepc = nMepcEna; bMret = nMretEna;
    mretE = 1; tmr_irq_r = 1;
    tick();
    mretE = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nReq - bReq >= 2) break;
    end
    tmr_irq_r = 0;
    ticks(6);
    chk("mret_pulses", 32'(nMretEna - bMret), 1);
    chk("mret_redirect", lastMretRpc, 32'h200);
    chk("mret_then_trap", 32'(nMepcEna - bMepc), 1);
    chk("mret_trap_mepc", lastMepc, 32'h300);
    chk("mret_order", 32'(lastMretEdge < lastMepcEdge), 1);

    // Ack never returns: timeout flag raises with the redirect and sticks.
    autoAck = 0; pc_resumeE = 32'h400;
    bMepc = nMepcEna;
    tmr_irq_r = 1;
    tick();
    tmr_irq_r = 0;
    ticks(7);
    chk("to_err_early", 32'(trap_timeout_err), 0);
    tick();
    chk("to_err_set", 32'(trap_timeout_err), 1);
    chk("to_trap_rv", 32'(redirect_valid), 1);
    ticks(5);
    chk("to_err_sticky", 32'(trap_timeout_err), 1);
    chk("to_mepc_pulses", 32'(nMepcEna - bMepc), 1);
    reset = 0;
    tick();
    chk("to_err_clear", 32'(trap_timeout_err), 0);
    reset = 1;
    tick();

    // Reset held mid-drain aborts the sequence with no strobes.
    bMepc = nMepcEna;
    tmr_irq_r = 1;
    tick();
    tmr_irq_r = 0;
    ticks(2);
    reset = 0;
    ticks(3);
    chk("rmid_stall", 32'(stallF), 0);
    chk("rmid_req", 32'(empty_pipeline_reqE), 0);
    reset = 1;
    ticks(12);
    chk("rmid_no_trap", 32'(nMepcEna - bMepc), 0);
    chk("rmid_no_err", 32'(trap_timeout_err), 0);
    autoAck = 1;

    // Interrupts masked plus a stray ack in IDLE: nothing happens.
    bReq = nReq;
    csr_mstatus_mie_r = 0; tmr_irq_r = 1; ext_irq_r = 1; strayAck = 1;
    tick();
    strayAck = 0;
    ticks(5);
    csr_mstatus_mie_r = 1; csr_mtie_r = 0; csr_meie_r = 0;
    ticks(3);
    chk("masked_no_req", 32'(nReq - bReq), 0);
    chk("masked_no_stall", 32'(stallF), 0);
    tmr_irq_r = 0; ext_irq_r = 0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
